down_cnt_timer: RTL and testbench

Loadable, pausable down-counter timer with an internal clock-enable prescaler, built as the counting-down counterpart of the lab's divided-clock binary up-counter. Software or board switches load a start value. The block then decrements once per prescaled tick and flags terminal count. It runs entirely on the board clock: the divided rate is produced by a tick enable, not a derived clock. It sits between board inputs (switches/buttons) and the LED/seven-segment display path.

---
 rtl/down_cnt_timer.sv | 96 +++++++++
 tb/tb_down_cnt_timer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/down_cnt_timer.sv
// Loadable down-counter with a clock-enable prescaler; cnt/tc registered, one decrement per DIV enabled cycles.
// No backpressure: load always wins, en low freezes counter and prescaler in place.
module down_cnt_timer #(
  parameter int unsigned DIV = 4,
  parameter int unsigned W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         mode,
  output logic [W-1:0] cnt,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  cnt_nxt, reload, reload_nxt;
  logic [PW-1:0] prescaler, prescaler_nxt;
  logic          tc_nxt;
  logic          tick;

  assign tick = (state == S_RUN) && en && (prescaler == PS_MAX);
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      reload    <= '0;
      prescaler <= '0;
      tc        <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      reload    <= reload_nxt;
      prescaler <= prescaler_nxt;
      tc        <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    reload_nxt    = reload;
    prescaler_nxt = prescaler;
    tc_nxt        = 1'b0;
    if (load) begin
      cnt_nxt       = load_val;
      reload_nxt    = load_val;
      prescaler_nxt = '0;
      state_nxt     = (load_val != '0) ? S_RUN : S_IDLE;
    end else begin
      case (state)
        S_IDLE: prescaler_nxt = '0;
        S_RUN: begin
          if (tick) begin
            prescaler_nxt = '0;
            if (cnt > W'(1)) begin
              cnt_nxt = cnt - W'(1);
            end else begin
              // Terminal tick: mode is only looked at here
              tc_nxt = 1'b1;
              if (mode) begin
                cnt_nxt = reload;
              end else begin
                cnt_nxt   = '0;
                state_nxt = S_DONE;
              end
            end
          end else if (en) begin
            prescaler_nxt = prescaler + PW'(1);
          end
        end
        S_DONE: cnt_nxt = '0;
        default: begin
          state_nxt     = S_IDLE;
          prescaler_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_cnt_timer.sv
// Directed bench for down_cnt_timer: cycle table on a DIV=4 instance plus hand sequences and a DIV=1 instance.
module tb_down_cnt_timer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, load, en, mode;
  logic [3:0] load_val;
  logic [3:0] cnt;
  logic       tc, busy, done;

  logic       rst_b, load_b, en_b, mode_b;
  logic [3:0] load_val_b;
  logic [3:0] cnt_b;
  logic       tc_b, busy_b, done_b;

  int applied = 0;
  int miscompares = 0;

  down_cnt_timer #(.DIV(4), .W(4)) u_dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en), .mode(mode),
    .cnt(cnt), .tc(tc), .busy(busy), .done(done)
  );

  down_cnt_timer #(.DIV(1), .W(4)) u_dut1 (
    .clk(clk), .rst(rst_b), .load(load_b), .load_val(load_val_b), .en(en_b), .mode(mode_b),
    .cnt(cnt_b), .tc(tc_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic       rst, load;
    logic [3:0] lv;
    logic       en, mode;
    logic [3:0] cnt;
    logic       tc, busy, done;
  } vec_t;

  vec_t vq[$];

  function automatic void add(int n, logic r, logic l, logic [3:0] lv, logic e, logic m,
                              logic [3:0] c, logic t, logic b, logic d);
    vec_t v;
    v.rst = r; v.load = l; v.lv = lv; v.en = e; v.mode = m;
    v.cnt = c; v.tc = t; v.busy = b; v.done = d;
    repeat (n) vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got cnt/tc/busy/done=%0d/%b/%b/%b, want %0d/%b/%b/%b",
               name, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic [3:0] lv, input logic e, input logic m);
    rst = r; load = l; load_val = lv; en = e; mode = m;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  k;
    bit  seen;

    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst_b = 1'b0; load_b = 1'b0; load_val_b = 4'd0; en_b = 1'b0; mode_b = 1'b0;

    // reset held with load/en active, then idle after release
    add(2,  0, 1, 4'd5, 1, 0,  4'd0, 0, 0, 0);
    add(3,  1, 0, 4'd0, 1, 0,  4'd0, 0, 0, 0);
    // one-shot, load 3: steps at E4, E8, E12
    add(1,  1, 1, 4'd3, 1, 0,  4'd3, 0, 1, 0);
    add(3,  1, 0, 4'd0, 1, 0,  4'd3, 0, 1, 0);
    add(4,  1, 0, 4'd0, 1, 0,  4'd2, 0, 1, 0);
    add(4,  1, 0, 4'd0, 1, 0,  4'd1, 0, 1, 0);
    add(1,  1, 0, 4'd0, 1, 0,  4'd0, 1, 0, 1);
    add(20, 1, 0, 4'd0, 1, 0,  4'd0, 0, 0, 1);
    // auto-reload, load 2: tc after E8 and E16
    add(1,  1, 1, 4'd2, 1, 1,  4'd2, 0, 1, 0);
    add(3,  1, 0, 4'd0, 1, 1,  4'd2, 0, 1, 0);
    add(4,  1, 0, 4'd0, 1, 1,  4'd1, 0, 1, 0);
    add(1,  1, 0, 4'd0, 1, 1,  4'd2, 1, 1, 0);
    add(3,  1, 0, 4'd0, 1, 1,  4'd2, 0, 1, 0);
    add(4,  1, 0, 4'd0, 1, 1,  4'd1, 0, 1, 0);
    add(1,  1, 0, 4'd0, 1, 1,  4'd2, 1, 1, 0);
    add(3,  1, 0, 4'd0, 1, 1,  4'd2, 0, 1, 0);
    // load of zero goes idle and never fires
    add(1,  1, 1, 4'd0, 1, 0,  4'd0, 0, 0, 0);
    add(10, 1, 0, 4'd0, 1, 0,  4'd0, 0, 0, 0);
    // pause: en low for 6 edges after E5 pushes second decrement to E14
    add(1,  1, 1, 4'd5, 1, 0,  4'd5, 0, 1, 0);
    add(3,  1, 0, 4'd0, 1, 0,  4'd5, 0, 1, 0);
    add(2,  1, 0, 4'd0, 1, 0,  4'd4, 0, 1, 0);
    add(6,  1, 0, 4'd0, 0, 0,  4'd4, 0, 1, 0);
    add(2,  1, 0, 4'd0, 1, 0,  4'd4, 0, 1, 0);
    add(1,  1, 0, 4'd0, 1, 0,  4'd3, 0, 1, 0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].load, vq[i].lv, vq[i].en, vq[i].mode);
      step();
      check($sformatf("vec%0d", i), {cnt, tc, busy, done},
            {vq[i].cnt, vq[i].tc, vq[i].busy, vq[i].done});
    end

    // load collides with the terminal tick of a count from 1
    drive(1, 1, 4'd1, 1, 0); step();
    check("coll_load", {cnt, tc, busy, done}, {4'd1, 1'b0, 1'b1, 1'b0});
    drive(1, 0, 4'd0, 1, 0);
    repeat (3) step();
    drive(1, 1, 4'd9, 1, 0); step();
    check("coll_tick", {cnt, tc, busy, done}, {4'd9, 1'b0, 1'b1, 1'b0});
    drive(1, 0, 4'd0, 1, 0);
    repeat (4) step();
    check("coll_next", {cnt, tc, busy, done}, {4'd8, 1'b0, 1'b1, 1'b0});

    // en drops exactly on the would-be tick cycle
    drive(1, 1, 4'd2, 1, 0); step();
    drive(1, 0, 4'd0, 1, 0);
    repeat (3) step();
    drive(1, 0, 4'd0, 0, 0); step();
    check("endrop_hold", {cnt, tc, busy, done}, {4'd2, 1'b0, 1'b1, 1'b0});
    drive(1, 0, 4'd0, 1, 0); step();
    check("endrop_tick", {cnt, tc, busy, done}, {4'd1, 1'b0, 1'b1, 1'b0});

    // reset mid-count wins over load and en
    drive(1, 1, 4'd7, 1, 0); step();
    check("rst_pre", {cnt, tc, busy, done}, {4'd7, 1'b0, 1'b1, 1'b0});
    drive(0, 1, 4'd9, 1, 1); step();
    check("rst_mid", {cnt, tc, busy, done}, {4'd0, 1'b0, 1'b0, 1'b0});
    drive(1, 0, 4'd0, 1, 0);
    repeat (3) step();
    check("rst_idle", {cnt, tc, busy, done}, {4'd0, 1'b0, 1'b0, 1'b0});

    // DIV=1, load 15: tc exactly 15 edges after the load edge
    check("d1_reset", {cnt_b, tc_b, busy_b, done_b}, {4'd0, 1'b0, 1'b0, 1'b0});
    rst_b = 1'b1; load_b = 1'b1; load_val_b = 4'd15; en_b = 1'b1; mode_b = 1'b0;
    step();
    check("d1_load", {cnt_b, tc_b, busy_b, done_b}, {4'd15, 1'b0, 1'b1, 1'b0});
    load_b = 1'b0;
    k = 0;
    seen = 1'b0;
    while (k < 40 && !seen) begin
      step();
      k++;
      if (tc_b) seen = 1'b1;
    end
    check_int("d1_tc_edges", k, 15);
    check("d1_tc_state", {cnt_b, tc_b, busy_b, done_b}, {4'd0, 1'b1, 1'b0, 1'b1});
    step();
    check("d1_after", {cnt_b, tc_b, busy_b, done_b}, {4'd0, 1'b0, 1'b0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
